// File: rtl/udp_reg_ring_master_pkg.sv
// Shared constants for the UDP register ring master: status codes, FSM states, filler data.
package udp_reg_ring_master_pkg;

    localparam int unsigned STATUS_W = 2;

    localparam logic [STATUS_W-1:0] RSP_OK      = 2'b00;
    localparam logic [STATUS_W-1:0] RSP_NOACK   = 2'b01;
    localparam logic [STATUS_W-1:0] RSP_TIMEOUT = 2'b10;

    // Returned in place of read data when nobody acknowledged the request
    localparam logic [31:0] NOACK_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Width of a counter that must reach cycles-1; at least one bit
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/udp_reg_ring_master_if.sv
// Command/response port plus ring launch/return path of the ring master.
interface udp_reg_ring_master_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SRC_W  = 2
);
    import udp_reg_ring_master_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_rd_wr_L;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wr_data;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rd_data;
    logic [STATUS_W-1:0] rsp_status;

    logic                reg_req_in;
    logic                reg_ack_in;
    logic                reg_rd_wr_L_in;
    logic [ADDR_W-1:0]   reg_addr_in;
    logic [DATA_W-1:0]   reg_data_in;
    logic [SRC_W-1:0]    reg_src_in;

    logic                reg_req_out;
    logic                reg_ack_out;
    logic                reg_rd_wr_L_out;
    logic [ADDR_W-1:0]   reg_addr_out;
    logic [DATA_W-1:0]   reg_data_out;
    logic [SRC_W-1:0]    reg_src_out;

    // The ring master itself
    modport slave (
        input  cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wr_data, rsp_ready,
        input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
        output cmd_ready, rsp_valid, rsp_rd_data, rsp_status,
        output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
    );

    // Local control logic plus the rest of the ring
    modport master (
        output cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wr_data, rsp_ready,
        output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
        input  cmd_ready, rsp_valid, rsp_rd_data, rsp_status,
        input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
    );

endinterface

// File: rtl/udp_reg_ring_master.sv
// Ring head: injects one command onto the register ring and waits for it to come back.
module udp_reg_ring_master
    import udp_reg_ring_master_pkg::*;
#(
    parameter int unsigned                  UDP_REG_ADDR_WIDTH = 23,
    parameter int unsigned                  DATA_WIDTH         = 32,
    parameter int unsigned                  UDP_REG_SRC_WIDTH  = 2,
    parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID             = UDP_REG_SRC_WIDTH'(1),
    parameter int unsigned                  TIMEOUT_CYCLES     = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    udp_reg_ring_master_if.slave       bus
);

    localparam int unsigned AW    = UDP_REG_ADDR_WIDTH;
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned SW    = UDP_REG_SRC_WIDTH;
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0]    FILL     = DW'(NOACK_DATA);

    state_e               state_q, state_d;

    logic                 req_out_q,  req_out_d;
    logic                 ack_out_q,  ack_out_d;
    logic                 rdwr_out_q, rdwr_out_d;
    logic [AW-1:0]        addr_out_q, addr_out_d;
    logic [DW-1:0]        data_out_q, data_out_d;
    logic [SW-1:0]        src_out_q,  src_out_d;

    logic                 rsp_valid_q,  rsp_valid_d;
    logic [DW-1:0]        rsp_data_q,   rsp_data_d;
    logic [STATUS_W-1:0]  rsp_status_q, rsp_status_d;

    logic [AW-1:0]        cap_addr_q, cap_addr_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;

    logic                 foreign_in;
    logic                 own_in;
    logic                 match_c;
    logic                 timeout_c;
    logic                 cmd_ready_c;
    logic                 cmd_fire;

    // Ring-side classification of the incoming word and command handshake
    assign foreign_in  = bus.reg_req_in & (bus.reg_src_in != SRC_ID);
    assign own_in      = bus.reg_req_in & (bus.reg_src_in == SRC_ID);
    assign match_c     = own_in & (bus.reg_addr_in == cap_addr_q);
    assign timeout_c   = (cnt_q == CNT_LAST);
    // Blocked while a foreign word needs the launch registers; held low in reset
    assign cmd_ready_c = ~reset & (state_q == ST_IDLE) & ~foreign_in;
    assign cmd_fire    = bus.cmd_valid & cmd_ready_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_fire)            state_d = ST_WAIT;
            ST_WAIT: if (match_c | timeout_c) state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready)       state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic: ring launch word, timeout counter, response
    always_comb begin
        req_out_d    = 1'b0;
        ack_out_d    = 1'b0;
        rdwr_out_d   = 1'b0;
        addr_out_d   = '0;
        data_out_d   = '0;
        src_out_d    = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        cap_addr_d   = cap_addr_q;
        cnt_d        = cnt_q;

        // Own injection first, then foreign pass-through; own-tag returns are never forwarded
        if (cmd_fire) begin
            req_out_d  = 1'b1;
            ack_out_d  = 1'b0;
            rdwr_out_d = bus.cmd_rd_wr_L;
            addr_out_d = bus.cmd_addr;
            data_out_d = bus.cmd_rd_wr_L ? '0 : bus.cmd_wr_data;
            src_out_d  = SRC_ID;
        end else if (foreign_in) begin
            req_out_d  = bus.reg_req_in;
            ack_out_d  = bus.reg_ack_in;
            rdwr_out_d = bus.reg_rd_wr_L_in;
            addr_out_d = bus.reg_addr_in;
            data_out_d = bus.reg_data_in;
            src_out_d  = bus.reg_src_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    cap_addr_d = bus.cmd_addr;
                    cnt_d      = '0;
                end
            end
            ST_WAIT: begin
                if (match_c) begin
                    rsp_valid_d = 1'b1;
                    if (bus.reg_ack_in) begin
                        rsp_status_d = RSP_OK;
                        rsp_data_d   = bus.reg_data_in;
                    end else begin
                        rsp_status_d = RSP_NOACK;
                        rsp_data_d   = FILL;
                    end
                end else if (timeout_c) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = RSP_TIMEOUT;
                    rsp_data_d   = FILL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_out_q    <= 1'b0;
            ack_out_q    <= 1'b0;
            rdwr_out_q   <= 1'b0;
            addr_out_q   <= '0;
            data_out_q   <= '0;
            src_out_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            cap_addr_q   <= '0;
            cnt_q        <= '0;
        end else begin
            req_out_q    <= req_out_d;
            ack_out_q    <= ack_out_d;
            rdwr_out_q   <= rdwr_out_d;
            addr_out_q   <= addr_out_d;
            data_out_q   <= data_out_d;
            src_out_q    <= src_out_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            cap_addr_q   <= cap_addr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.cmd_ready       = cmd_ready_c;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rd_data     = rsp_data_q;
    assign bus.rsp_status      = rsp_status_q;
    assign bus.reg_req_out     = req_out_q;
    assign bus.reg_ack_out     = ack_out_q;
    assign bus.reg_rd_wr_L_out = rdwr_out_q;
    assign bus.reg_addr_out    = addr_out_q;
    assign bus.reg_data_out    = data_out_q;
    assign bus.reg_src_out     = src_out_q;

endmodule
